program_counter_stack: RTL and testbench
========================================

Name: program_counter_stack

Overview:
Parametrised next-generation program counter for the teaching CPU datapath. It adds a hardware return-address stack (call/return), a hold input, signed relative branching of configurable width and sticky stack-error flags. It sits between the instruction-fetch address bus and the control unit. Its CounterValue drives instruction memory and the decimal seven-segment display path.

Parameters:
WIDTH, 16, counter/address width in bits
OFFSET_WIDTH, 9, width of signed two's-complement Offset input
DEPTH, 8, return-address stack entries (>=2)
RESET_VALUE, 0, CounterValue after reset

Ports:
Clock  input  1  single clock, all state updates on rising edge
ResetN  input  1  synchronous, active-low reset
Hold  input  1  freeze counter and stack (no increment) when no other command active
LoadEnable  input  1  absolute jump to LoadValue
LoadValue  input  WIDTH  jump/call target
OffsetEnable  input  1  relative branch: CounterValue + sign-extended Offset
Offset  input  OFFSET_WIDTH  signed branch offset
Call  input  1  push CounterValue+1, jump to LoadValue
Return  input  1  pop top of stack into CounterValue
ClearErrors  input  1  clear Overflow/Underflow flags
CounterValue  output  WIDTH  current program counter
StackDepth  output  $clog2(DEPTH+1)  number of valid stack entries
Overflow  output  1  sticky: Call attempted while stack full
Underflow  output  1  sticky: Return attempted while stack empty

Behaviour:
- Reset (ResetN=0 at rising edge): CounterValue=RESET_VALUE, StackDepth=0, Overflow=0, Underflow=0; overrides all other inputs, including mid-call or mid-return.
- Single-cycle latency: each command takes effect at the next rising edge. No multi-cycle states.
- Command priority, highest first: Call > Return > LoadEnable > OffsetEnable > Hold > increment.
- Increment (no command, Hold=0): CounterValue <= CounterValue+1.
- LoadEnable: CounterValue <= LoadValue.
- OffsetEnable: CounterValue <= CounterValue + sign-extended Offset.
- Call, not full: stack[StackDepth] <= CounterValue+1; StackDepth+1; CounterValue <= LoadValue.
- Call, full (StackDepth==DEPTH): jump still performed; push discarded; stack unchanged; Overflow <= 1.
- Return, not empty: CounterValue <= stack[StackDepth-1]; StackDepth-1.
- Return, empty: CounterValue holds; StackDepth stays 0; Underflow <= 1.
- Simultaneous Call and Return: Call wins; Return is ignored and does not set Underflow.
- All arithmetic is modulo 2^WIDTH. FFFF+1 -> 0000. 0002 + (-5) -> FFFD for WIDTH=16. The pushed return address wraps the same way.
- ClearErrors clears both flags. If a new error occurs in the same cycle, the error wins and its flag reads 1.
- Flags change only on error events, ClearErrors or reset.
- Stack is LIFO storage indexed by StackDepth. Contents above StackDepth are don't-care.

Optional Feature:
Macro PC_STACK_TOS_EN.
- Defined: adds output port TopOfStack [WIDTH-1:0] = stack[StackDepth-1] when StackDepth>0, else 0. The port is combinational from registered state and is used by the debug display.
- Undefined: the port does not exist; all other behaviour is identical.

Test Plan:
- Reset then 5 free-running clocks -> CounterValue 0,1,2,3,4,5; StackDepth 0; flags 0. Assert ResetN=0 during a Call: next value 0, depth 0.
- Load 0x00F0, then OffsetEnable with Offset=-16 (9'h1F0) -> 0x00E0. Offset=+255 from 0xFFF0 -> 0x00EF (wrap).
- From PC 0x0010: Call to 0x0100, run 3 cycles, then Return -> PC 0x0011, StackDepth 1->0. Nested 3 calls then 3 returns pop in reverse order.
- DEPTH=8: 9 consecutive Calls -> 9th jumps, StackDepth stays 8, Overflow=1. ClearErrors -> Overflow=0.
- Return with empty stack -> PC holds, Underflow=1. Call+Return same cycle -> Call executes, depth+1, Underflow stays 0.
- Hold=1 for 4 cycles -> PC constant. Hold=1 with LoadEnable=1 -> load still occurs. With PC_STACK_TOS_EN defined, TopOfStack equals the last pushed address.

Source files
------------

// File: rtl/program_counter_stack.sv
// program_counter_stack
//   Program counter with a hardware return-address stack, hold, signed
//   relative branching and sticky stack-error flags. Every command takes
//   effect at the next rising edge of Clock. No command needs more than one
//   cycle.
//
//   Command priority (highest first):
//     Call > Return > LoadEnable > OffsetEnable > Hold > increment
//
//   Optional build macro: PC_STACK_TOS_EN
//     When defined, adds the TopOfStack output. TopOfStack is the newest
//     stack entry, or zero when the stack is empty.
//
//   Ports:
//     Clock        rising-edge clock for all state
//     ResetN       synchronous active-low reset
//     Hold         freeze counter when no other command is active
//     LoadEnable   absolute jump to LoadValue
//     LoadValue    jump/call target
//     OffsetEnable relative branch by sign-extended Offset
//     Offset       signed two's-complement branch offset
//     Call         push CounterValue+1 and jump to LoadValue
//     Return       pop top of stack into CounterValue
//     ClearErrors  clear Overflow/Underflow (a same-cycle error wins)
//     CounterValue current program counter
//     StackDepth   number of valid stack entries
//     Overflow     sticky: Call attempted while the stack was full
//     Underflow    sticky: Return attempted while the stack was empty
//     TopOfStack   (PC_STACK_TOS_EN only) newest stack entry, or 0 if empty
module program_counter_stack #(
  parameter int               WIDTH        = 16,
  parameter int               OFFSET_WIDTH = 9,
  parameter int               DEPTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                       Clock,
  input  logic                       ResetN,
  input  logic                       Hold,
  input  logic                       LoadEnable,
  input  logic [WIDTH-1:0]           LoadValue,
  input  logic                       OffsetEnable,
  input  logic [OFFSET_WIDTH-1:0]    Offset,
  input  logic                       Call,
  input  logic                       Return,
  input  logic                       ClearErrors,
  output logic [WIDTH-1:0]           CounterValue,
  output logic [$clog2(DEPTH+1)-1:0] StackDepth,
  output logic                       Overflow,
  output logic                       Underflow
`ifdef PC_STACK_TOS_EN
  ,output logic [WIDTH-1:0]          TopOfStack
`endif
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  // Modulo-2^WIDTH relative branch target.
  // The size cast sign-extends the signed offset.
  function automatic logic [WIDTH-1:0] add_offset(
    input logic [WIDTH-1:0]               pc,
    input logic signed [OFFSET_WIDTH-1:0] off
  );
    logic signed [WIDTH-1:0] off_ext;
    off_ext = WIDTH'(off);
    return pc + off_ext;
  endfunction

  logic [WIDTH-1:0] stack [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_nxt;
  logic [DW-1:0]    depth_nxt;
  logic [DW-1:0]    depth_m1;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic             full;
  logic             empty;
  logic             push_en;
  logic             ovf_nxt;
  logic             unf_nxt;

  assign pc_inc   = CounterValue + WIDTH'(1);
  assign full     = (StackDepth == DW'(DEPTH));
  assign empty    = (StackDepth == '0);
  assign depth_m1 = StackDepth - DW'(1);
  // Indices are only used when they are in range:
  // push_idx when the stack is not full, pop_idx when it is not empty.
  assign push_idx = StackDepth[AW-1:0];
  assign pop_idx  = depth_m1[AW-1:0];

  always_comb begin
    pc_nxt    = pc_inc;
    depth_nxt = StackDepth;
    push_en   = 1'b0;
    // Clear first. A same-cycle error below overrides the clear.
    ovf_nxt   = ClearErrors ? 1'b0 : Overflow;
    unf_nxt   = ClearErrors ? 1'b0 : Underflow;
    if (Call) begin
      // The jump happens even when the stack is full; only the push is lost.
      pc_nxt = LoadValue;
      if (full) begin
        ovf_nxt = 1'b1;
      end else begin
        push_en   = 1'b1;
        depth_nxt = StackDepth + DW'(1);
      end
    end else if (Return) begin
      if (empty) begin
        pc_nxt  = CounterValue;
        unf_nxt = 1'b1;
      end else begin
        pc_nxt    = stack[pop_idx];
        depth_nxt = depth_m1;
      end
    end else if (LoadEnable) begin
      pc_nxt = LoadValue;
    end else if (OffsetEnable) begin
      pc_nxt = add_offset(CounterValue, Offset);
    end else if (Hold) begin
      pc_nxt = CounterValue;
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      CounterValue <= RESET_VALUE;
      StackDepth   <= '0;
      Overflow     <= 1'b0;
      Underflow    <= 1'b0;
    end else begin
      CounterValue <= pc_nxt;
      StackDepth   <= depth_nxt;
      Overflow     <= ovf_nxt;
      Underflow    <= unf_nxt;
    end
  end

  // Stack storage is never reset.
  // Entries at or above StackDepth are don't-care.
  always_ff @(posedge Clock) begin
    if (push_en && ResetN) begin
      stack[push_idx] <= pc_inc;
    end
  end

`ifdef PC_STACK_TOS_EN
  assign TopOfStack = empty ? '0 : stack[pop_idx];
`endif

endmodule

// File: tb/tb_program_counter_stack.sv
module tb_program_counter_stack;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        Hold;
  logic        LoadEnable;
  logic [15:0] LoadValue;
  logic        OffsetEnable;
  logic [8:0]  Offset;
  logic        Call;
  logic        Return;
  logic        ClearErrors;
  logic [15:0] CounterValue;
  logic [3:0]  StackDepth;
  logic        Overflow;
  logic        Underflow;
`ifdef PC_STACK_TOS_EN
  logic [15:0] TopOfStack;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Observed state, packed as {pc[15:0], depth[3:0], ovf, unf}.
  logic [21:0] st;
  assign st = {CounterValue, StackDepth, Overflow, Underflow};

  program_counter_stack #(
    .WIDTH(16), .OFFSET_WIDTH(9), .DEPTH(8), .RESET_VALUE(16'h0000)
  ) dut (
    .Clock(Clock), .ResetN(ResetN), .Hold(Hold), .LoadEnable(LoadEnable),
    .LoadValue(LoadValue), .OffsetEnable(OffsetEnable), .Offset(Offset),
    .Call(Call), .Return(Return), .ClearErrors(ClearErrors),
    .CounterValue(CounterValue), .StackDepth(StackDepth),
    .Overflow(Overflow), .Underflow(Underflow)
`ifdef PC_STACK_TOS_EN
    , .TopOfStack(TopOfStack)
`endif
  );

  always #5 Clock = ~Clock;

  function automatic logic [21:0] mk(input logic [15:0] pc, input logic [3:0] d,
                                     input logic o, input logic u);
    return {pc, d, o, u};
  endfunction

  task automatic clr();
    ResetN = 1'b1; Hold = 1'b0; LoadEnable = 1'b0; LoadValue = 16'h0000;
    OffsetEnable = 1'b0; Offset = 9'h000; Call = 1'b0; Return = 1'b0;
    ClearErrors = 1'b0;
  endtask

  // Inputs change 1 ns after a rising edge.
  // Outputs are sampled 1 ns after the following edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    clr();
    ResetN = 1'b0;
    step();
    clr();
  endtask

  task automatic test_reset();
    logic [21:0] e;
    clr(); ResetN = 1'b0; LoadEnable = 1'b1; LoadValue = 16'h1234; step(); clr();
    e = mk(16'h0000, 4'd0, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL reset_state got %h exp %h", st, e); end
    for (int i = 1; i <= 5; i++) begin
      step();
      e = mk(16'(i), 4'd0, 1'b0, 1'b0); n_checks++;
      if (st !== e) begin n_fail++; $display("FAIL free_run_%0d got %h exp %h", i, st, e); end
    end
    Call = 1'b1; LoadValue = 16'h0100; step();
    e = mk(16'h0100, 4'd1, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL pre_reset_call got %h exp %h", st, e); end
    ResetN = 1'b0; LoadValue = 16'h0200; step(); clr();
    e = mk(16'h0000, 4'd0, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL reset_mid_call got %h exp %h", st, e); end
    Return = 1'b1; step(); clr();
    ResetN = 1'b0; Return = 1'b1; step(); clr();
    e = mk(16'h0000, 4'd0, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL reset_clears_flag got %h exp %h", st, e); end
  endtask

  task automatic test_offset();
    logic [15:0] ld  [4] = '{16'h00F0, 16'hFFF0, 16'h0002, 16'h7FFF};
    logic [8:0]  off [4] = '{9'h1F0,   9'h0FF,   9'h1FB,   9'h001};
    logic [15:0] res [4] = '{16'h00E0, 16'h00EF, 16'hFFFD, 16'h8000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      LoadEnable = 1'b1; LoadValue = ld[i]; step(); clr();
      n_checks++;
      if (CounterValue !== ld[i]) begin
        n_fail++; $display("FAIL load_%0d got %h exp %h", i, CounterValue, ld[i]);
      end
      OffsetEnable = 1'b1; Offset = off[i]; step(); clr();
      n_checks++;
      if (CounterValue !== res[i]) begin
        n_fail++; $display("FAIL offset_%0d got %h exp %h", i, CounterValue, res[i]);
      end
    end
    LoadEnable = 1'b1; LoadValue = 16'hFFFF; step(); clr(); step();
    n_checks++;
    if (CounterValue !== 16'h0000) begin
      n_fail++; $display("FAIL inc_wrap got %h exp 0000", CounterValue);
    end
  endtask

  task automatic test_call_return();
    logic [21:0] e;
    logic [15:0] tgt [3] = '{16'h0200, 16'h0300, 16'h0400};
    logic [15:0] ret [3] = '{16'h0301, 16'h0201, 16'h0021};
    do_reset();
    LoadEnable = 1'b1; LoadValue = 16'h0010; step(); clr();
    Call = 1'b1; LoadValue = 16'h0100; step(); clr();
    e = mk(16'h0100, 4'd1, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL call_single got %h exp %h", st, e); end
    step(); step(); step();
    Return = 1'b1; step(); clr();
    e = mk(16'h0011, 4'd0, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL return_single got %h exp %h", st, e); end
    LoadEnable = 1'b1; LoadValue = 16'h0020; step(); clr();
    for (int i = 0; i < 3; i++) begin
      Call = 1'b1; LoadValue = tgt[i]; step(); clr();
      e = mk(tgt[i], 4'(i + 1), 1'b0, 1'b0); n_checks++;
      if (st !== e) begin n_fail++; $display("FAIL nested_call_%0d got %h exp %h", i, st, e); end
`ifdef PC_STACK_TOS_EN
      n_checks++;
      if (TopOfStack !== ret[2 - i]) begin
        n_fail++; $display("FAIL tos_%0d got %h exp %h", i, TopOfStack, ret[2 - i]);
      end
`endif
    end
    for (int i = 0; i < 3; i++) begin
      Return = 1'b1; step(); clr();
      e = mk(ret[i], 4'(2 - i), 1'b0, 1'b0); n_checks++;
      if (st !== e) begin n_fail++; $display("FAIL nested_ret_%0d got %h exp %h", i, st, e); end
    end
`ifdef PC_STACK_TOS_EN
    n_checks++;
    if (TopOfStack !== 16'h0000) begin
      n_fail++; $display("FAIL tos_empty got %h exp 0000", TopOfStack);
    end
`endif
    LoadEnable = 1'b1; LoadValue = 16'hFFFF; step(); clr();
    Call = 1'b1; LoadValue = 16'h0050; step(); clr();
    Return = 1'b1; step(); clr();
    e = mk(16'h0000, 4'd0, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL push_wrap got %h exp %h", st, e); end
  endtask

  task automatic test_overflow();
    logic [21:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      Call = 1'b1; LoadValue = 16'h1000 + 16'(i); step(); clr();
      e = mk(16'h1000 + 16'(i), 4'(i + 1), 1'b0, 1'b0); n_checks++;
      if (st !== e) begin n_fail++; $display("FAIL fill_call_%0d got %h exp %h", i, st, e); end
    end
    Call = 1'b1; LoadValue = 16'h1008; step(); clr();
    e = mk(16'h1008, 4'd8, 1'b1, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL overflow_call got %h exp %h", st, e); end
    step();
    e = mk(16'h1009, 4'd8, 1'b1, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL overflow_sticky got %h exp %h", st, e); end
    ClearErrors = 1'b1; step(); clr();
    e = mk(16'h100A, 4'd8, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL overflow_clear got %h exp %h", st, e); end
    ClearErrors = 1'b1; Call = 1'b1; LoadValue = 16'h2000; step(); clr();
    e = mk(16'h2000, 4'd8, 1'b1, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL clear_vs_error got %h exp %h", st, e); end
    ClearErrors = 1'b1; step(); clr();
    Return = 1'b1; step(); clr();
    e = mk(16'h1007, 4'd7, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL pop_after_full got %h exp %h", st, e); end
  endtask

  task automatic test_underflow();
    logic [21:0] e;
    do_reset();
    Return = 1'b1; step(); clr();
    e = mk(16'h0000, 4'd0, 1'b0, 1'b1); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL underflow_ret got %h exp %h", st, e); end
    step();
    e = mk(16'h0001, 4'd0, 1'b0, 1'b1); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL underflow_sticky got %h exp %h", st, e); end
    ClearErrors = 1'b1; step(); clr();
    e = mk(16'h0002, 4'd0, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL underflow_clear got %h exp %h", st, e); end
    Call = 1'b1; Return = 1'b1; LoadValue = 16'h0400; step(); clr();
    e = mk(16'h0400, 4'd1, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL call_and_return got %h exp %h", st, e); end
    Return = 1'b1; step(); clr();
    e = mk(16'h0003, 4'd0, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL ret_after_both got %h exp %h", st, e); end
    Return = 1'b1; ClearErrors = 1'b1; step(); clr();
    e = mk(16'h0003, 4'd0, 1'b0, 1'b1); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL clear_vs_underflow got %h exp %h", st, e); end
  endtask

  task automatic test_hold_priority();
    logic [21:0] e;
    do_reset();
    LoadEnable = 1'b1; LoadValue = 16'h0050; step(); clr();
    Hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (CounterValue !== 16'h0050) begin
        n_fail++; $display("FAIL hold_%0d got %h exp 0050", i, CounterValue);
      end
    end
    LoadEnable = 1'b1; LoadValue = 16'h0060; step(); clr();
    n_checks++;
    if (CounterValue !== 16'h0060) begin
      n_fail++; $display("FAIL hold_load got %h exp 0060", CounterValue);
    end
    step();
    n_checks++;
    if (CounterValue !== 16'h0061) begin
      n_fail++; $display("FAIL hold_release got %h exp 0061", CounterValue);
    end
    Call = 1'b1; LoadValue = 16'h0080; step(); clr();
    Return = 1'b1; LoadEnable = 1'b1; OffsetEnable = 1'b1; Hold = 1'b1;
    LoadValue = 16'h0500; Offset = 9'h005; step(); clr();
    e = mk(16'h0062, 4'd0, 1'b0, 1'b0); n_checks++;
    if (st !== e) begin n_fail++; $display("FAIL prio_return got %h exp %h", st, e); end
    LoadEnable = 1'b1; OffsetEnable = 1'b1; LoadValue = 16'h0500; Offset = 9'h005; step(); clr();
    n_checks++;
    if (CounterValue !== 16'h0500) begin
      n_fail++; $display("FAIL prio_load got %h exp 0500", CounterValue);
    end
    OffsetEnable = 1'b1; Hold = 1'b1; Offset = 9'h1FF; step(); clr();
    n_checks++;
    if (CounterValue !== 16'h04FF) begin
      n_fail++; $display("FAIL prio_offset got %h exp 04FF", CounterValue);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_offset();
    test_call_return();
    test_overflow();
    test_underflow();
    test_hold_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
